// File: rtl/csp_merge11_if.sv
// Handshake bundle for the two-input four-phase merge: two producer channels,
// one merged consumer channel and the delivered-token counter.
interface csp_merge11_if #(
  parameter int WIDTH = 11
);
  logic             in1_req;
  logic [WIDTH-1:0] in1_data;
  logic             in1_ack;
  logic             in2_req;
  logic [WIDTH-1:0] in2_data;
  logic             in2_ack;
  logic             out_req;
  logic [WIDTH-1:0] out_data;
  logic             out_ack;
  logic [7:0]       count;

  modport master (
    input  in1_req, in1_data, in2_req, in2_data, out_ack,
    output in1_ack, in2_ack, out_req, out_data, count
  );

  modport slave (
    output in1_req, in1_data, in2_req, in2_data, out_ack,
    input  in1_ack, in2_ack, out_req, out_data, count
  );
endinterface

// File: rtl/csp_merge11.sv
// Four-phase two-into-one merge with round-robin arbitration and a count of
// tokens fully delivered downstream.
module csp_merge11 #(
  parameter int WIDTH = 11
) (
  input  logic         clk,
  input  logic         reset_n,
  csp_merge11_if.master bus
);

  typedef enum logic [1:0] {IDLE, SEND, RTZ} state_t;

  state_t           state, state_nx;
  logic             ack1, ack2;
  logic             last2;
  logic [WIDTH-1:0] data_q;
  logic [7:0]       cnt;
  logic             elig1, elig2, grant1, grant2;
  logic             capture, deliver;

  always_comb begin
    state_nx = state;
    capture  = 1'b0;
    deliver  = 1'b0;
    // A channel whose ack is still high has already been taken.
    elig1    = bus.in1_req & ~ack1;
    elig2    = bus.in2_req & ~ack2;
    grant1   = elig1 & (~elig2 | last2);
    grant2   = elig2 & (~elig1 | ~last2);
    case (state)
      IDLE: if (elig1 | elig2) begin
        state_nx = SEND;
        capture  = 1'b1;
      end
      SEND: if (bus.out_ack) begin
        state_nx = RTZ;
        deliver  = 1'b1;
      end
      RTZ:  if (!bus.out_ack) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack1   <= 1'b0;
      ack2   <= 1'b0;
      last2  <= 1'b1;
      data_q <= '0;
      cnt    <= '0;
    end else begin
      // Input-side return-to-zero runs independently of the output FSM.
      if (ack1 && !bus.in1_req)   ack1 <= 1'b0;
      else if (capture && grant1) ack1 <= 1'b1;
      if (ack2 && !bus.in2_req)   ack2 <= 1'b0;
      else if (capture && grant2) ack2 <= 1'b1;
      if (capture) begin
        data_q <= grant1 ? bus.in1_data : bus.in2_data;
        last2  <= grant2;
      end
      if (deliver) cnt <= cnt + 8'd1;
    end
  end

  assign bus.in1_ack  = ack1;
  assign bus.in2_ack  = ack2;
  assign bus.out_req  = (state == SEND);
  assign bus.out_data = data_q;
  assign bus.count    = cnt;

endmodule

// File: doc/csp_merge11.md
CSP_MERGE11 -- requirements
Module: csp_merge11

Interface
REQ-001 Parameter: WIDTH, default 11, data width of every channel.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 reset_n  input  1  reset, asynchronous and active-low.
REQ-004 in1_req  input  1  four-phase request, input channel 1.
REQ-005 in1_data  input  WIDTH  channel 1 bundled data; stable while in1_req=1.
REQ-006 in1_ack  output  1  four-phase acknowledge, channel 1.
REQ-007 in2_req, in2_data, in2_ack  as REQ-004..006, channel 2.
REQ-008 out_req  output  1  four-phase request, merged output.
REQ-009 out_data  output  WIDTH  merged data; stable while out_req=1.
REQ-010 out_ack  input  1  four-phase acknowledge from downstream.
REQ-011 count  output  8  number of tokens fully delivered downstream, modulo 256.

Function
REQ-012 Role: this block is the merge, the inverse of the split. Each token accepted on in1 or in2 is forwarded unmodified on out, one token at a time.
REQ-013 All inputs are synchronous to clk; no synchronizers are included.
REQ-014 Output FSM states: IDLE (out_req=0), SEND (out_req=1), RTZ (out_req=0). The FSM resets to IDLE.
REQ-015 Input channel k is eligible when ink_req=1 and ink_ack=0.
REQ-016 Capture happens only in IDLE with at least one eligible channel. On that edge:
- out_data is loaded from the granted channel;
- out_req goes to 1 and the FSM moves to SEND;
- the granted ink_ack goes to 1.
REQ-017 Latency: when an eligible request is sampled in IDLE at edge N, out_req and ink_ack are both 1 after edge N.
REQ-018 SEND with out_ack=1 sampled: out_req goes to 0, the FSM moves to RTZ, and count increments (wraps 255->0).
REQ-019 RTZ with out_ack=0 sampled: the FSM moves to IDLE. A new capture is earliest at the next edge.
REQ-020 ink_ack stays 1 until ink_req=0 is sampled, then goes to 0 on that edge. This is independent of the output FSM state.
REQ-021 A channel whose ack is still high is not eligible, even if its req has risen again. This forbids double capture.
REQ-022 Arbitration is round-robin:
- a last_grant register holds the last channel granted;
- if both channels are eligible, the channel other than last_grant wins;
- if one channel is eligible, it wins and last_grant is updated to it.
REQ-023 The losing channel keeps its request pending with ack=0. It is served at the next IDLE capture.
REQ-024 out_data holds its value from capture until the next capture, including through RTZ and IDLE.
REQ-025 out_ack=1 sampled in IDLE or RTZ is ignored. out_ack=0 sampled in SEND is a wait (no change).
REQ-026 The minimum full cycle per token, with a zero-wait downstream, is 3 clocks: capture, ack-seen, RTZ-seen.

Reset
REQ-027 While reset_n=0, the following hold immediately, independent of clk:
- out_req=0, in1_ack=0, in2_ack=0;
- out_data=0, count=0;
- FSM=IDLE;
- last_grant=2, so in1 wins the first tie.
REQ-028 Reset asserted mid-handshake abandons the token in flight; count is not incremented for it.
REQ-029 After reset_n rises, the first capture is possible at the first rising edge with reset_n=1.
REQ-030 Input reqs held high across reset are captured as fresh eligible requests after release.

Verification
REQ-031 Single token:
- stimulus: in1_data=11'b10111000111, in1_req=1; downstream acks one cycle after out_req;
- response: out_data=11'b10111000111, in1_ack=1 one edge after req, count=1 after RTZ.
REQ-032 Tie after reset:
- stimulus: in1 and in2 requests asserted at the same edge, in1=11'h001, in2=11'h03D;
- response: out carries 11'h001 first, then 11'h03D; in2_ack stays 0 until the second capture; count=2.
REQ-033 Fairness:
- stimulus: both channels re-request continuously for 6 tokens;
- response: output order is in1, in2, in1, in2, in1, in2.
REQ-034 Back-pressure:
- stimulus: out_ack held 0 for 10 cycles in SEND while in2 requests;
- response: out_req and out_data are stable, in2_ack=0, count is unchanged.
- then: out_ack=1, then out_ack=0 -> in2 is captured on the edge after RTZ->IDLE.
REQ-035 Reset and wrap:
- stimulus: reset_n pulsed low while in SEND with in1_ack=1;
- response: all outputs return to REQ-027 values asynchronously.
- then: 256 tokens -> count wraps to 0.
REQ-036 Double-capture guard:
- stimulus: in1_req held high after in1_ack rises;
- response: no second capture; a second token is taken only after in1_req falls, in1_ack falls, and in1_req rises again.
